// File: rtl/mem_fill_ctrl_if.sv
// Bus bundle between mem_fill_ctrl, the cache controllers and main memory.
// master = the fill controller, slave = the cache/memory side.
interface mem_fill_ctrl_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16,
  parameter int WORDS  = 8
);
  // cache-side requests
  logic                       miss_req;
  logic [AWIDTH-1:0]          miss_addr;
  logic                       wr_req;
  logic [AWIDTH-1:0]          wr_addr;
  logic [DWIDTH-1:0]          wr_data;
  logic                       wr_ack;
  logic                       busy;

  // main memory port
  logic                       mem_enable;
  logic                       mem_wr;
  logic [AWIDTH-1:0]          mem_addr;
  logic [DWIDTH-1:0]          mem_wdata;
  logic [DWIDTH-1:0]          mem_rdata;
  logic                       mem_rvalid;
  logic [AWIDTH-1:0]          mem_raddr;

  // data array fill port
  logic                       fill_we;
  logic [$clog2(WORDS)-1:0]   fill_word;
  logic [DWIDTH-1:0]          fill_data;
  logic                       fill_done;
  logic                       fill_err;

  modport master (
    input  miss_req, miss_addr, wr_req, wr_addr, wr_data,
           mem_rdata, mem_rvalid, mem_raddr,
    output mem_enable, mem_wr, mem_addr, mem_wdata,
           fill_we, fill_word, fill_data, fill_done, fill_err, wr_ack, busy
  );

  modport slave (
    output miss_req, miss_addr, wr_req, wr_addr, wr_data,
           mem_rdata, mem_rvalid, mem_raddr,
    input  mem_enable, mem_wr, mem_addr, mem_wdata,
           fill_we, fill_word, fill_data, fill_done, fill_err, wr_ack, busy
  );
endinterface

// File: rtl/mem_fill_ctrl.sv
// Cache block fill initiator: issues WORDS pipelined reads on a miss, streams
// tagged returns into the data array, and forwards write-through stores in idle.
module mem_fill_ctrl #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16,
  parameter int WORDS  = 8
) (
  input  logic           clk,
  input  logic           rst,
  mem_fill_ctrl_if.master bus
);
  localparam int OFFW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] base;
  logic [OFFW-1:0]   issue_cnt, ret_cnt;
  logic              err_q;
  logic              accept_miss, ret_acc, tag_bad;
  logic [AWIDTH-1:0] issue_addr, exp_raddr;

  always_comb begin
    state_nxt      = state;
    accept_miss    = 1'b0;
    ret_acc        = 1'b0;
    tag_bad        = 1'b0;
    issue_addr     = base + AWIDTH'({issue_cnt, 1'b0});
    exp_raddr      = base + AWIDTH'({ret_cnt, 1'b0});
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.fill_we    = 1'b0;
    bus.fill_word  = '0;
    bus.fill_data  = '0;
    bus.fill_done  = 1'b0;
    bus.wr_ack     = 1'b0;

    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.wr_req) begin
            bus.mem_enable = 1'b1;
            bus.mem_wr     = 1'b1;
            bus.mem_addr   = bus.wr_addr;
            bus.mem_wdata  = bus.wr_data;
            bus.wr_ack     = 1'b1;
          end else if (bus.miss_req) begin
            accept_miss = 1'b1;
            state_nxt   = ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = issue_addr;
          if (issue_cnt == OFFW'(WORDS - 1)) state_nxt = DRAIN;
        end
        DRAIN: ;
        DONE: begin
          bus.fill_done = 1'b1;
          state_nxt     = IDLE;
        end
        default: state_nxt = IDLE;
      endcase

      if ((state == ISSUE || state == DRAIN) && bus.mem_rvalid) begin
        ret_acc       = 1'b1;
        bus.fill_we   = 1'b1;
        bus.fill_word = bus.mem_raddr[OFFW:1];
        bus.fill_data = bus.mem_rdata;
        tag_bad       = (bus.mem_raddr != exp_raddr);
        if (ret_cnt == OFFW'(WORDS - 1)) state_nxt = DONE;
      end
    end
  end

  // A bad tag is flagged in the cycle it arrives and held by err_q afterwards.
  assign bus.fill_err = err_q | tag_bad;
  assign bus.busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_miss) begin
        base      <= bus.miss_addr & ~AWIDTH'(2 * WORDS - 1);
        issue_cnt <= '0;
        ret_cnt   <= '0;
        err_q     <= 1'b0;
      end else begin
        if (state == ISSUE) issue_cnt <= issue_cnt + OFFW'(1);
        if (ret_acc)        ret_cnt   <= ret_cnt + OFFW'(1);
        if (tag_bad)        err_q     <= 1'b1;
      end
    end
  end
endmodule

// File: doc/mem_fill_ctrl.md
# mem_fill_ctrl

Memory-side initiator for the cache subsystem. On a cache miss it issues one block's worth of word reads to the multi-cycle main memory, one request per cycle. It collects the pipelined returns by tag address and streams each word into the cache data array, then pulses completion. In idle it also forwards single-cycle write-through stores to memory. It sits between the cache controllers and main memory, which has a 4-cycle read latency, single-cycle writes, and byte addressing with address bit 0 ignored.

## Interface
- AWIDTH, 16, address width
- DWIDTH, 16, data width
- WORDS, 8, words per cache block (power of 2); OFFW = log2(WORDS)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- miss_req  in  1  block fill request, sampled only in IDLE
- miss_addr  in  AWIDTH  any byte address in the missing block
- wr_req  in  1  write-through store request, held until wr_ack
- wr_addr  in  AWIDTH  store byte address
- wr_data  in  DWIDTH  store data
- mem_enable  out  1  memory request valid
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  AWIDTH  memory byte address
- mem_wdata  out  DWIDTH  memory write data
- mem_rdata  in  DWIDTH  memory read data
- mem_rvalid  in  1  memory read data valid
- mem_raddr  in  AWIDTH  address tag of returned data
- fill_we  out  1  write fill_data into the data array
- fill_word  out  OFFW  word offset within the block
- fill_data  out  DWIDTH  returned word
- fill_done  out  1  one-cycle pulse at fill completion; also the tag/valid write strobe
- fill_err  out  1  sticky flag: returned tag ≠ expected address; cleared by rst or next fill start
- wr_ack  out  1  one-cycle store acceptance
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - If wr_req: mem_enable=1, mem_wr=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1, all combinationally in the same cycle. Stay in IDLE.
  - Else if miss_req: base ← {miss_addr[AWIDTH-1:OFFW+1], 0}; issue_cnt, ret_cnt ← 0; fill_err ← 0; go to ISSUE.
  - wr_req wins when both are asserted. The miss is taken on the following IDLE cycle.
- ISSUE:
  - mem_enable=1, mem_wr=0, mem_addr = base + {issue_cnt, 1'b0}; issue_cnt increments each cycle.
  - After the issue with issue_cnt = WORDS-1, go to DRAIN.
- DRAIN: mem_enable=0. Wait for the remaining returns.
- Return handling in ISSUE and DRAIN, when mem_rvalid=1:
  - fill_we=1, fill_data=mem_rdata, fill_word=mem_raddr[OFFW:1]; ret_cnt increments.
  - If mem_raddr ≠ base + {ret_cnt, 1'b0}, set fill_err.
  - When the return with ret_cnt = WORDS-1 is accepted, go to DONE.
- DONE: fill_done=1 for one cycle, then IDLE.
- Outside ISSUE and DRAIN, mem_rvalid is ignored and fill_we=0.
- wr_req is not acknowledged while busy; the store is accepted on the first IDLE cycle.
- A miss_req drop mid-fill is ignored and the fill completes. miss_req still high in IDLE after DONE is treated as a new miss.
- Address arithmetic is modulo 2^AWIDTH. Blocks are aligned, so offsets never carry out of the block. Base 0xFFF0 issues 0xFFF0..0xFFFE.
- rst in any state: go to IDLE, clear counters, base and fill_err. Memory shares rst, so no stale returns follow.

## Timing
- Reset values: all outputs 0.
- Read latency: a read issued in cycle t returns with mem_rvalid in cycle t+4.
- Fill timeline, with miss_req seen in IDLE at cycle 0:
  - ISSUE in cycles 1–8.
  - DRAIN in cycles 9–12.
  - fill_we in cycles 5–12, fill_word 0..7 in order.
  - fill_done in cycle 13.
  - IDLE in cycle 14.
- Fill occupancy: 14 cycles from acceptance to the return to IDLE.
- Store: wr_ack and the memory write occur in the same cycle as wr_req in IDLE. There are no wait states.
- fill_we, fill_word and fill_data are combinational from mem_rvalid, mem_raddr and mem_rdata, gated by state.

## Test plan
- Basic fill: memory preloaded with word = byte address; miss_addr=0x123A at cycle 0. Expect:
  - reads to 0x1230..0x123E in cycles 1–8;
  - fill_we in cycles 5–12 with (word, data) = (0,0x1230)..(7,0x123E);
  - fill_done in cycle 13; fill_err=0.
- Top-of-memory block: miss_addr=0xFFFF. Expect reads 0xFFF0..0xFFFE with no wrap into 0x0000; fill_done in cycle 13.
- Collision: wr_req (0x0040, 0xBEEF) and miss_req (0x0100) in the same cycle. Expect wr_ack and the memory write at cycle 0, then fill issues in cycles 2–9.
- Store during fill: wr_req raised in cycle 3 of a fill. Expect wr_ack=0 until IDLE at cycle 14, then wr_ack with mem_wr=1.
- Reset mid-fill: rst asserted in cycle 7. Expect:
  - next cycle: IDLE, all outputs 0, no fill_we;
  - a new miss then completes normally in 14 cycles.
- Tag mismatch: the bench memory model returns mem_raddr for word 3 corrupted. Expect fill_err=1 from that cycle through fill_done; the next miss clears it.
